// File: rtl/multdiv.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring on magnitudes) unit.
// One request pulse starts a 32-iteration operation that ends with a one-cycle ready pulse.
module multdiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);
  localparam int W  = WIDTH;
  localparam int HW = W + 2;

  typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

  state_t            state;
  logic [5:0]        count;

  logic signed [HW-1:0] mcand;
  logic signed [HW-1:0] hi;
  logic [W-1:0]         lo;
  logic                 qm1;
  logic signed [HW-1:0] hi_sum;
  logic signed [HW-1:0] hi_nxt;
  logic [W-1:0]         lo_nxt;

  logic [W-1:0] divisor, rem, quot;
  logic         q_neg, div_zero, div_ovf;
  logic [W:0]   shifted, diff;
  logic         take;
  logic [W-1:0] rem_nxt, quot_nxt;

  logic req_mult, req_div, req, last_iter;

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? (~v + 1'b1) : v;
  endfunction

  // Quotient sign fix-up; divide-by-zero forces 0, and the single overflow
  // case (most-negative / -1) already yields 0x80000000 from the magnitudes.
  function automatic logic [W-1:0] div_result(input logic [W-1:0] q, input logic neg,
                                              input logic zero);
    if (zero) return '0;
    return neg ? (~q + 1'b1) : q;
  endfunction

  assign req_mult  = ctrl_MULT;
  assign req_div   = ctrl_DIV & ~ctrl_MULT;
  assign req       = ctrl_MULT | ctrl_DIV;
  assign last_iter = (count == 6'(W - 1));

  // Booth step: the two extra hi bits keep the most-negative multiplicand from overflowing.
  always_comb begin
    hi_sum = hi;
    case ({lo[0], qm1})
      2'b01:   hi_sum = hi + mcand;
      2'b10:   hi_sum = hi - mcand;
      default: hi_sum = hi;
    endcase
    hi_nxt = hi_sum >>> 1;
    lo_nxt = {hi_sum[0], lo[W-1:1]};
  end

  // Restoring-division step: borrow out of the 33-bit trial subtract rejects the bit.
  always_comb begin
    shifted  = {rem, quot[W-1]};
    diff     = shifted - {1'b0, divisor};
    take     = ~diff[W];
    rem_nxt  = take ? diff[W-1:0] : shifted[W-1:0];
    quot_nxt = {quot[W-2:0], take};
  end

  always_ff @(posedge clock) begin
    if (req_mult) begin
      mcand <= $signed({{2{data_operandA[W-1]}}, data_operandA});
      hi    <= '0;
      lo    <= data_operandB;
      qm1   <= 1'b0;
    end else if (req_div) begin
      divisor  <= mag(data_operandB);
      rem      <= '0;
      quot     <= mag(data_operandA);
      q_neg    <= data_operandA[W-1] ^ data_operandB[W-1];
      div_zero <= (data_operandB == '0);
      div_ovf  <= (data_operandA == {1'b1, {(W-1){1'b0}}}) && (data_operandB == '1);
    end else if (state == MULT) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      qm1 <= lo[0];
    end else if (state == DIV) begin
      rem  <= rem_nxt;
      quot <= quot_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (req) begin
        state <= req_mult ? MULT : DIV;
        count <= '0;
      end else if (state != IDLE) begin
        count <= count + 6'd1;
        if (last_iter) begin
          state          <= IDLE;
          data_resultRDY <= 1'b1;
          if (state == MULT) begin
            data_result    <= lo_nxt;
            data_exception <= (hi_nxt[W-1:0] != {W{lo_nxt[W-1]}});
          end else begin
            data_result    <= div_result(quot_nxt, q_neg, div_zero);
            data_exception <= div_zero | div_ovf;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv.sv
// Directed bench for multdiv: vector table plus abort and reset sequences.
module tb_multdiv;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;

  int compared = 0;
  int failed   = 0;

  localparam logic [1:0] OP_MUL = 2'd0, OP_DIV = 2'd1, OP_BOTH = 2'd2;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t vecs[11];

  multdiv #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; the request is sampled on the next posedge, returns at the
  // following negedge with inputs scrambled so mid-operation changes are exercised.
  task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = (op == OP_MUL) || (op == OP_BOTH);
    ctrl_DIV      = (op == OP_DIV) || (op == OP_BOTH);
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_done(input string name, input logic [31:0] res, input logic exc);
    int n = 0;
    while (!data_resultRDY && n < 40) begin
      @(negedge clock);
      n++;
    end
    check({name, " latency"}, 32'(n), 32'd32);
    check({name, " result"}, data_result, res);
    check({name, " exception"}, {31'd0, data_exception}, {31'd0, exc});
    @(negedge clock);
    check({name, " rdy one cycle"}, {31'd0, data_resultRDY}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{OP_MUL,  32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{OP_MUL,  32'h00010000,   32'h00010000, 32'h00000000, 1'b1};
    vecs[2]  = '{OP_MUL,  32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[3]  = '{OP_MUL,  32'hFFFF0000,   32'h00008000, 32'h80000000, 1'b0};
    vecs[4]  = '{OP_DIV,  32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{OP_DIV,  32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    vecs[6]  = '{OP_DIV,  32'hFFFFFFF9,   32'hFFFFFFFE, 32'd3,        1'b0};
    vecs[7]  = '{OP_DIV,  32'd100,        32'd7,        32'd14,       1'b0};
    vecs[8]  = '{OP_DIV,  32'd5,          32'd0,        32'd0,        1'b1};
    vecs[9]  = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[10] = '{OP_BOTH, 32'd6,          32'd3,        32'd18,       1'b0};

    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    check("reset result", data_result, 32'd0);
    check("reset exception", {31'd0, data_exception}, 32'd0);
    check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 11; i++) begin
      start(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), vecs[i].res, vecs[i].exc);
      repeat (2) @(negedge clock);
    end

    // Abort: MULT 3x4 overridden by DIV 100/7 on the 10th edge.
    start(OP_MUL, 32'd3, 32'd4);
    for (int k = 1; k <= 9; k++) begin
      check($sformatf("abort hold result e%0d", k), data_result, 32'd18);
      check($sformatf("abort no rdy e%0d", k), {31'd0, data_resultRDY}, 32'd0);
      if (k < 9) @(negedge clock);
    end
    start(OP_DIV, 32'd100, 32'd7);
    wait_done("abort div", 32'd14, 1'b0);
    begin
      int extra = 0;
      for (int k = 0; k < 40; k++) begin
        if (data_resultRDY) extra++;
        @(negedge clock);
      end
      check("abort single pulse", 32'(extra), 32'd0);
    end

    // Reset mid-operation, after loading a nonzero result with exception set.
    start(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("pre-reset", 32'h80000000, 1'b1);
    start(OP_MUL, 32'd3, 32'd4);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset result", data_result, 32'd0);
    check("midreset exception", {31'd0, data_exception}, 32'd0);
    check("midreset rdy", {31'd0, data_resultRDY}, 32'd0);
    begin
      int pulses = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clock);
        if (data_resultRDY) pulses++;
      end
      check("midreset no pulse", 32'(pulses), 32'd0);
    end
    check("midreset result held", data_result, 32'd0);

    start(OP_MUL, 32'd3, 32'd4);
    wait_done("post-reset mult", 32'd12, 1'b0);

    start(OP_BOTH, 32'd6, 32'd3);
    wait_done("both priority", 32'd18, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
